icache_refill_responder: RTL

Memory-side responder for the instruction-cache refill interface. Accepts a one-cycle line request (16-byte aligned address) and returns one 128-bit line with a one-cycle ready pulse after a fixed, parameterised latency. A newer request cancels any request in flight, which matches the cache re-issuing on a jump redirect. Holds the instruction image in a word array that a side load port writes, used for boot and testbench preload.

---
 rtl/icache_refill_pkg.sv | 20 ++
 rtl/icache_refill_responder_if.sv | 26 ++
 rtl/imem_line_ram.sv | 30 +++
 rtl/icache_refill_responder.sv | 120 ++++++++++++
 4 files changed

// File: rtl/icache_refill_pkg.sv
// Shared definitions for the instruction-cache refill path.
// Used by both the cache and the memory-side responder.
package icache_refill_pkg;

  localparam int unsigned LINE_BYTES     = 16;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned LINE_W         = 128;
  localparam int unsigned WORDS_PER_LINE = 4;

  typedef enum logic {
    IDLE,
    WAIT
  } refill_state_e;

  // Line address of a byte address; the low nibble is the offset within the line.
  function automatic logic [27:0] line_addr(input logic [31:0] addr);
    return addr[31:4];
  endfunction

endpackage

// File: rtl/icache_refill_responder_if.sv
// Refill request/response bus plus the side preload port.
// The master side is the cache; the slave side is the responder.
interface icache_refill_responder_if;
  import icache_refill_pkg::*;

  logic              req_valid_i;
  logic [31:0]       req_addr_i;
  logic              mem_ready_o;
  logic [LINE_W-1:0] mem_data_o;
  logic              err_o;
  logic              busy_o;
  logic              load_we_i;
  logic [31:0]       load_addr_i;
  logic [WORD_W-1:0] load_data_i;

  modport master (
    output req_valid_i, req_addr_i, load_we_i, load_addr_i, load_data_i,
    input  mem_ready_o, mem_data_o, err_o, busy_o
  );

  modport slave (
    input  req_valid_i, req_addr_i, load_we_i, load_addr_i, load_data_i,
    output mem_ready_o, mem_data_o, err_o, busy_o
  );

endinterface

// File: rtl/imem_line_ram.sv
// Instruction image storage: one 32-bit write port, one combinational line-wide read port.
// Not reset; contents come from the preload port.
module imem_line_ram
  import icache_refill_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned WORD_AW     = $clog2(DEPTH_WORDS),
  parameter int unsigned LINE_AW     = WORD_AW - 2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [WORD_AW-1:0] waddr,
  input  logic [WORD_W-1:0] wdata,
  input  logic [LINE_AW-1:0] rline,
  output logic [LINE_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  for (genvar k = 0; k < WORDS_PER_LINE; k++) begin : g_rd
    assign rdata[k*WORD_W +: WORD_W] = mem[{rline, 2'(k)}];
  end

endmodule

// File: rtl/icache_refill_responder.sv
// Memory-side refill responder: returns one line a fixed LATENCY after each request;
// a newer request replaces any request still in flight.
module icache_refill_responder
  import icache_refill_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned LATENCY     = 4,
  parameter logic [31:0] ADDR_BASE   = 32'h0000_0000
) (
  input logic                      clk,
  input logic                      rst_n,
  icache_refill_responder_if.slave bus
);

  localparam int unsigned LINES      = DEPTH_WORDS / WORDS_PER_LINE;
  localparam int unsigned WORD_AW    = $clog2(DEPTH_WORDS);
  localparam int unsigned LINE_AW    = WORD_AW - 2;
  localparam int unsigned CNT_W      = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(LATENCY - 1);

  refill_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [LINE_AW-1:0] line_q, line_d;
  logic               oor_q, oor_d;
  logic               ready_q, ready_d;
  logic               err_q, err_d;
  logic [LINE_W-1:0]  data_q, data_d;

  logic [31:0]        req_rel, load_rel;
  logic               req_borrow, load_borrow;
  logic [27:0]        req_line;
  logic               req_oor, load_ok, complete;
  logic [LINE_W-1:0]  ram_line;

  // The borrow out of the subtraction flags addresses below ADDR_BASE.
  assign {req_borrow, req_rel}   = {1'b0, bus.req_addr_i} - {1'b0, ADDR_BASE};
  assign {load_borrow, load_rel} = {1'b0, bus.load_addr_i} - {1'b0, ADDR_BASE};
  assign req_line = line_addr(req_rel);
  assign req_oor  = req_borrow || ({4'b0, req_line} >= LINES);
  assign load_ok  = bus.load_we_i && !load_borrow && ((load_rel >> 2) < DEPTH_WORDS);

  imem_line_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .WORD_AW     (WORD_AW),
    .LINE_AW     (LINE_AW)
  ) u_ram (
    .clk   (clk),
    .we    (load_ok),
    .waddr (load_rel[WORD_AW+1:2]),
    .wdata (bus.load_data_i),
    .rline (line_q),
    .rdata (ram_line)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      line_q  <= '0;
      oor_q   <= 1'b0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      line_q  <= line_d;
      oor_q   <= oor_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    line_d  = line_q;
    oor_d   = oor_q;
    unique case (state_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          state_d = WAIT;
          cnt_d   = CNT_RELOAD;
          line_d  = req_line[LINE_AW-1:0];
          oor_d   = req_oor;
        end
      end
      WAIT: begin
        // A fresh request restarts the wait and silently drops the old one.
        if (bus.req_valid_i) begin
          cnt_d  = CNT_RELOAD;
          line_d = req_line[LINE_AW-1:0];
          oor_d  = req_oor;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  assign complete = (state_q == WAIT) && !bus.req_valid_i && (cnt_q == '0);

  always_comb begin
    ready_d = complete;
    err_d   = complete && oor_q;
    data_d  = data_q;
    if (complete) begin
      data_d = oor_q ? '0 : ram_line;
    end
  end

  assign bus.mem_ready_o = ready_q;
  assign bus.err_o       = err_q;
  assign bus.mem_data_o  = data_q;
  assign bus.busy_o      = (state_q == WAIT);

endmodule
